// File: rtl/wb_master_engine.sv
// Wishbone B3 master: executes one command of 1..16 single beats with retry and error handling.
// Define WB_MASTER_TIMEOUT_EN to abort a beat the slave leaves unanswered for TIMEOUT cycles.
module wb_master_engine #(
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_len,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_XFER  = 3'd2,
    S_RETRY = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d, rd_data_q, rd_data_d;
  logic [3:0]    sel_q, sel_d, len_q, len_d, beat_q, beat_d;
  logic          we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
  logic          done_q, done_d, rd_valid_q, rd_valid_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    status_q, status_d, fin_status_s;
  logic [RW-1:0] retry_q, retry_d, retry_inc_s;
  logic          wd_take_s;

  assign retry_inc_s = retry_q + RW'(1);
  assign wd_take_s   = (state_q == S_LOAD) && we_q && wd_valid;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0] tmo_q, tmo_d, tmo_inc_s;
  logic       tmo_hit_s;
  assign tmo_inc_s = tmo_q + 8'd1;
  assign tmo_hit_s = (tmo_inc_s == TIMEOUT_C);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and completion code; err beats rty beats ack
  always_comb begin
    state_d      = state_q;
    fin_status_s = ST_OK;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = S_LOAD;
        else           state_d = S_IDLE;
      end
      S_LOAD: begin
        if (!we_q || wd_valid) state_d = S_XFER;
        else                   state_d = S_LOAD;
      end
      S_XFER: begin
        if (wb_err_i) begin
          state_d      = S_DONE;
          fin_status_s = ST_ERR;
        end else if (wb_rty_i) begin
          if (retry_inc_s <= MAX_RETRY_C) begin
            state_d = S_RETRY;
          end else begin
            state_d      = S_DONE;
            fin_status_s = ST_RTY;
          end
        end else if (wb_ack_i) begin
          if (beat_q == len_q) state_d = S_DONE;
          else                 state_d = S_LOAD;
        end else begin
`ifdef WB_MASTER_TIMEOUT_EN
          if (tmo_hit_s) begin
            state_d      = S_DONE;
            fin_status_s = ST_TMO;
          end else begin
            state_d = S_XFER;
          end
`else
          state_d = S_XFER;
`endif
        end
      end
      S_RETRY: state_d = S_XFER;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus, stream and bookkeeping outputs
  always_comb begin
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    len_d      = len_q;
    beat_d     = beat_q;
    retry_d    = retry_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          len_d   = cmd_len;
          beat_d  = 4'd0;
          retry_d = '0;
        end else begin
          adr_d = adr_q;
        end
      end
      S_LOAD: begin
        if (wd_take_s) dat_d = wd_data;
        else           dat_d = dat_q;
      end
      S_XFER: begin
        if (wb_err_i) begin
          retry_d = retry_q;
        end else if (wb_rty_i) begin
          retry_d = retry_inc_s;
        end else if (wb_ack_i) begin
          if (!we_q) begin
            rd_data_d  = wb_dat_i;
            rd_valid_d = 1'b1;
          end else begin
            rd_valid_d = 1'b0;
          end
          if (beat_q != len_q) begin
            adr_d   = adr_q + 32'd4;
            beat_d  = beat_q + 4'd1;
            retry_d = '0;
          end else begin
            retry_d = retry_q;
          end
        end else begin
          retry_d = retry_q;
        end
      end
      default: retry_d = retry_q;
    endcase

    cyc_d  = (state_d == S_LOAD) || (state_d == S_XFER) || (state_d == S_RETRY);
    stb_d  = (state_d == S_XFER);
    done_d = (state_d == S_DONE);

    if ((state_d == S_DONE) && (state_q != S_DONE)) status_d = fin_status_s;
    else                                            status_d = status_q;

    if (len_d == 4'd0)         cti_d = CTI_CLASSIC;
    else if (beat_d == len_d)  cti_d = CTI_EOB;
    else                       cti_d = CTI_INCR;

`ifdef WB_MASTER_TIMEOUT_EN
    if (state_q != S_XFER)                          tmo_d = 8'd0;
    else if (!(wb_err_i || wb_rty_i || wb_ack_i))   tmo_d = tmo_inc_s;
    else                                            tmo_d = tmo_q;
`endif
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      we_q       <= 1'b0;
      len_q      <= 4'd0;
      beat_q     <= 4'd0;
      retry_q    <= '0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
      cti_q      <= 3'b000;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q      <= 8'd0;
`endif
    end else begin
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      retry_q    <= retry_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      done_q     <= done_d;
      status_q   <= status_d;
      cti_q      <= cti_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wd_ready  = wd_take_s;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign status    = status_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_cti_o  = cti_q;
  assign wb_bte_o  = 2'b00;

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: table of commands against a scripted Wishbone slave,
// plus timeout and mid-transfer reset sequences.
module tb_wb_master_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'd0;
  logic [3:0]  cmd_sel = 4'd0, cmd_len = 4'd0;
  logic        wd_valid = 1'b0, wd_ready;
  logic [31:0] wd_data = 32'd0;
  logic        rd_valid, done;
  logic [31:0] rd_data;
  logic [1:0]  status;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  int total = 0;
  int bad   = 0;

  wb_master_engine #(.MAX_RETRY(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .status(status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [3:0]  len;
    logic [31:0] d0;
    int          ack_wait;
    int          rty0;
    int          err_beat;
    logic        err_ack;
    int          gap1;
    logic [1:0]  exp_status;
    int          exp_stb;
    int          exp_idle;
    int          exp_hs;
    int          exp_rd;
  } vec_t;

  vec_t vecs [10];
  vec_t tmo_vec;
  vec_t hang_vec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input logic [31:0] d0, input int b);
    return d0 + (32'(b) * 32'h01010101);
  endfunction

  task automatic run_vec(input vec_t v, input int id, input int budget, input bit expect_done);
    int beat = 0, xcnt = 0, rused = 0, wi = 0, gapcnt = 0, gap_need;
    int stb_n = 0, idle_n = 0, hs_n = 0, rd_n = 0, done_n = 0;
    logic [1:0]  st = 2'b00;
    bit          fin = 1'b0;
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready_idle", id), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_sel = v.sel; cmd_len = v.len;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_cmd_ready_busy", id), 32'(cmd_ready), 32'd0);
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (rd_valid) begin
        chk($sformatf("v%0d_rd_data%0d", id, rd_n), rd_data, rdat(v.d0, rd_n));
        rd_n++;
      end
      if (done) begin
        done_n++;
        st  = status;
        fin = 1'b1;
      end
      if (wb_cyc_o && !wb_stb_o) idle_n++;
      if (wb_stb_o) begin
        stb_n++;
        exp_adr = v.adr + 32'(beat * 4);
        if (v.len == 4'd0)           exp_cti = 3'b000;
        else if (beat < int'(v.len)) exp_cti = 3'b010;
        else                         exp_cti = 3'b111;
        chk($sformatf("v%0d_adr_b%0d", id, beat), wb_adr_o, exp_adr);
        chk($sformatf("v%0d_cti_b%0d", id, beat), 32'(wb_cti_o), 32'(exp_cti));
        chk($sformatf("v%0d_bte", id), 32'(wb_bte_o), 32'd0);
        chk($sformatf("v%0d_we", id), 32'(wb_we_o), 32'(v.we));
        chk($sformatf("v%0d_sel", id), 32'(wb_sel_o), 32'(v.sel));
        if (v.we) chk($sformatf("v%0d_wdat_b%0d", id, beat), wb_dat_o, v.d0 + 32'(beat));
        if (xcnt >= v.ack_wait) begin
          xcnt = 0;
          if (beat == v.err_beat) begin
            wb_err_i = 1'b1;
            wb_ack_i = v.err_ack;
          end else if (beat == 0 && rused < v.rty0) begin
            wb_rty_i = 1'b1;
            rused++;
          end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = rdat(v.d0, beat);
            beat++;
          end
        end else begin
          xcnt++;
        end
      end
      gap_need = (wi == 1) ? v.gap1 : 0;
      if (v.we && wi <= int'(v.len)) begin
        if (gapcnt >= gap_need) begin
          wd_valid = 1'b1;
          wd_data  = v.d0 + 32'(wi);
        end else begin
          wd_valid = 1'b0;
          gapcnt++;
        end
      end else begin
        wd_valid = 1'b0;
      end
      #1;
      if (wd_valid && wd_ready) begin
        hs_n++;
        wi++;
        gapcnt = 0;
      end
    end
    wd_valid = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    if (expect_done) begin
      chk($sformatf("v%0d_done_seen", id), 32'(fin), 32'd1);
      chk($sformatf("v%0d_status", id), 32'(st), 32'(v.exp_status));
      chk($sformatf("v%0d_stb_cycles", id), 32'(stb_n), 32'(v.exp_stb));
      chk($sformatf("v%0d_cyc_no_stb_cycles", id), 32'(idle_n), 32'(v.exp_idle));
      chk($sformatf("v%0d_wd_handshakes", id), 32'(hs_n), 32'(v.exp_hs));
      chk($sformatf("v%0d_rd_beats", id), 32'(rd_n), 32'(v.exp_rd));
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", id), 32'(done), 32'd0);
      chk($sformatf("v%0d_cmd_ready_after", id), 32'(cmd_ready), 32'd1);
      chk($sformatf("v%0d_cyc_after", id), 32'(wb_cyc_o), 32'd0);
    end else begin
      chk($sformatf("v%0d_no_done", id), 32'(done_n), 32'd0);
      chk($sformatf("v%0d_stb_held_cycles", id), 32'(stb_n), 32'(budget - 1));
      chk($sformatf("v%0d_stb_still_high", id), 32'(wb_stb_o), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1);
  end

  initial begin
    //          we    adr            sel   len   d0             aw  rty err ea    gap st     stb idle hs rd
    vecs[0] = '{1'b0, 32'h00000100, 4'hF, 4'd0, 32'hDEADBEEF, 1,  0, -1, 1'b0, 0, 2'b00, 2,  1,   0, 1};
    vecs[1] = '{1'b1, 32'h00000200, 4'hF, 4'd3, 32'h00000001, 0,  0, -1, 1'b0, 3, 2'b00, 4,  6,   4, 0};
    vecs[2] = '{1'b0, 32'h00000300, 4'hF, 4'd0, 32'h11110000, 0,  2, -1, 1'b0, 0, 2'b00, 3,  3,   0, 1};
    vecs[3] = '{1'b0, 32'h00000304, 4'hF, 4'd0, 32'h22220000, 0,  5, -1, 1'b0, 0, 2'b10, 5,  5,   0, 0};
    vecs[4] = '{1'b0, 32'h00000400, 4'hF, 4'd2, 32'h33330000, 0,  0,  1, 1'b0, 0, 2'b01, 2,  2,   0, 1};
    vecs[5] = '{1'b0, 32'h00000500, 4'hF, 4'd2, 32'h33340000, 0,  0,  1, 1'b1, 0, 2'b01, 2,  2,   0, 1};
    vecs[6] = '{1'b0, 32'hFFFFFFFC, 4'hF, 4'd1, 32'h44440000, 0,  0, -1, 1'b0, 0, 2'b00, 2,  2,   0, 2};
    vecs[7] = '{1'b1, 32'h00000010, 4'h3, 4'd0, 32'hCAFE0001, 2,  0, -1, 1'b0, 0, 2'b00, 3,  1,   1, 0};
    vecs[8] = '{1'b0, 32'h00000600, 4'hF, 4'd0, 32'h55550000, 0,  4, -1, 1'b0, 0, 2'b00, 5,  5,   0, 1};
    vecs[9] = '{1'b1, 32'h00000700, 4'hC, 4'd1, 32'h66660000, 0,  1, -1, 1'b0, 0, 2'b00, 3,  3,   2, 0};
    tmo_vec  = '{1'b0, 32'h00000800, 4'hF, 4'd0, 32'h77770000, 100000, 0, -1, 1'b0, 0, 2'b11, 255, 1, 0, 0};
    hang_vec = '{1'b0, 32'h00000900, 4'hF, 4'd0, 32'h88880000, 100000, 0, -1, 1'b0, 0, 2'b00, 0,   0, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_cyc", 32'(wb_cyc_o), 32'd0);
    chk("reset_stb", 32'(wb_stb_o), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_adr", wb_adr_o, 32'd0);
    chk("reset_cti", 32'(wb_cti_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k, 60, 1'b1);

`ifdef WB_MASTER_TIMEOUT_EN
    run_vec(tmo_vec, 10, 400, 1'b1);
    run_vec(hang_vec, 11, 5, 1'b0);
`else
    run_vec(tmo_vec, 10, 300, 1'b0);
`endif

    // Reset while the strobe is up
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("midrst_stb", 32'(wb_stb_o), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_wd_ready", 32'(wd_ready), 32'd0);
    chk("midrst_adr", wb_adr_o, 32'd0);
    chk("midrst_dat", wb_dat_o, 32'd0);
    chk("midrst_sel", 32'(wb_sel_o), 32'd0);
    chk("midrst_we", 32'(wb_we_o), 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    chk("midrst_status", 32'(status), 32'd0);
    chk("midrst_cti", 32'(wb_cti_o), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_done", 32'(done), 32'd0);
    run_vec(vecs[0], 20, 60, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
